// File: rtl/ws2812_pkg.sv
// Shared types and 50 MHz timing defaults for the WS2812 frame transmitter.
package ws2812_pkg;

    typedef enum logic [2:0] {IDLE, FETCH, LOAD, SHIFT, GAP} state_t;

    localparam int PIXEL_BITS    = 24;
    localparam int DEF_BIT_CYC   = 62;
    localparam int DEF_T0H_CYC   = 20;
    localparam int DEF_T1H_CYC   = 40;
    localparam int DEF_RESET_CYC = 14000;

endpackage

// File: rtl/ws2812_bit_encoder.sv
// Drives one WS2812 bit period on dout per strobe; bit_end flags the last cycle of the period.
module ws2812_bit_encoder
    import ws2812_pkg::*;
#(
    parameter int BIT_CYC = DEF_BIT_CYC,
    parameter int T0H_CYC = DEF_T0H_CYC,
    parameter int T1H_CYC = DEF_T1H_CYC
) (
    input  logic clk,
    input  logic rst_n,
    input  logic strobe,
    input  logic bit_val,
    output logic dout,
    output logic bit_end
);
    localparam int CW = $clog2(BIT_CYC);

    logic [CW-1:0] cyc;
    logic          active;
    logic          bit_q;

    assign bit_end = active && (cyc == CW'(BIT_CYC - 1));

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cyc    <= '0;
            active <= 1'b0;
            bit_q  <= 1'b0;
            dout   <= 1'b0;
        end else if (strobe) begin
            cyc    <= '0;
            active <= 1'b1;
            bit_q  <= bit_val;
            dout   <= bit_val ? (T1H_CYC > 0) : (T0H_CYC > 0);
        end else if (bit_end) begin
            cyc    <= '0;
            active <= 1'b0;
            dout   <= 1'b0;
        end else if (active) begin
            cyc  <= cyc + 1'b1;
            dout <= (int'(cyc) + 1) < (bit_q ? T1H_CYC : T0H_CYC);
        end
    end

endmodule

// File: rtl/ws2812_frame_tx.sv
// Reads data_depth GRB words from the frame buffer and serializes them onto the WS2812 line.
// Define WS2812_TX_REPEAT_EN to retransmit the frame continuously after the first start.
module ws2812_frame_tx
    import ws2812_pkg::*;
#(
    parameter int ADDR_WIDTH = 10,
    parameter int BIT_CYC    = DEF_BIT_CYC,
    parameter int T0H_CYC    = DEF_T0H_CYC,
    parameter int T1H_CYC    = DEF_T1H_CYC,
    parameter int RESET_CYC  = DEF_RESET_CYC
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [15:0]           data_depth,
    output logic                  rd_en,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic [23:0]           rd_data,
    output logic                  dout,
    output logic                  busy,
    output logic                  done
);
    localparam int          GW      = $clog2(RESET_CYC + 1);
    localparam logic [16:0] MAX_PIX = 17'(2 ** ADDR_WIDTH);

    state_t                state, state_next;
    logic [PIXEL_BITS-1:0] shift_q, next_px;
    logic [4:0]            bit_cnt;
    logic [16:0]           pix_count, pix_idx;
    logic [GW-1:0]         gap_cnt;
    logic                  cap_pending;
    logic                  accept, more, more_after, done_d;
    logic                  enc_strobe, enc_bit, bit_end;

    // more: another pixel follows the current one; more_after: one follows that too.
    assign more       = (pix_idx + 17'd1) < pix_count;
    assign more_after = (pix_idx + 17'd2) < pix_count;

    ws2812_bit_encoder #(
        .BIT_CYC (BIT_CYC),
        .T0H_CYC (T0H_CYC),
        .T1H_CYC (T1H_CYC)
    ) u_enc (
        .clk     (clk),
        .rst_n   (rst_n),
        .strobe  (enc_strobe),
        .bit_val (enc_bit),
        .dout    (dout),
        .bit_end (bit_end)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path can infer a latch.
        state_next = state;
        accept     = 1'b0;
        done_d     = 1'b0;
        enc_strobe = 1'b0;
        enc_bit    = 1'b0;
        case (state)
            IDLE: if (start && data_depth != 16'd0) begin
                accept     = 1'b1;
                state_next = FETCH;
            end
            FETCH: state_next = LOAD;
            LOAD: begin
                state_next = SHIFT;
                enc_strobe = 1'b1;
                enc_bit    = rd_data[PIXEL_BITS-1];
            end
            SHIFT: if (bit_end) begin
                if (bit_cnt != 5'd0) begin
                    enc_strobe = 1'b1;
                    enc_bit    = shift_q[PIXEL_BITS-2];
                end else if (more) begin
                    enc_strobe = 1'b1;
                    enc_bit    = next_px[PIXEL_BITS-1];
                end else begin
                    state_next = GAP;
                end
            end
            GAP: begin
                done_d = (gap_cnt == GW'(RESET_CYC - 1));
                if (gap_cnt == GW'(RESET_CYC)) begin
`ifdef WS2812_TX_REPEAT_EN
                    state_next = FETCH;
`else
                    state_next = IDLE;
`endif
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_en       <= 1'b0;
            rd_addr     <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            shift_q     <= '0;
            next_px     <= '0;
            bit_cnt     <= '0;
            pix_count   <= '0;
            pix_idx     <= '0;
            gap_cnt     <= '0;
            cap_pending <= 1'b0;
        end else begin
            rd_en       <= 1'b0;
            done        <= done_d;
            busy        <= (state_next != IDLE);
            // Prefetch data arrives one cycle after its strobe.
            cap_pending <= rd_en && (state == SHIFT);
            if (cap_pending) next_px <= rd_data;
            case (state)
                IDLE: if (accept) begin
                    pix_count <= (17'(data_depth) > MAX_PIX) ? MAX_PIX : 17'(data_depth);
                    pix_idx   <= '0;
                    rd_en     <= 1'b1;
                    rd_addr   <= '0;
                end
                LOAD: begin
                    shift_q <= rd_data;
                    bit_cnt <= 5'(PIXEL_BITS - 1);
                    if (more) begin
                        rd_en   <= 1'b1;
                        rd_addr <= ADDR_WIDTH'(pix_idx + 17'd1);
                    end
                end
                SHIFT: if (bit_end) begin
                    if (bit_cnt != 5'd0) begin
                        shift_q <= shift_q << 1;
                        bit_cnt <= bit_cnt - 5'd1;
                    end else if (more) begin
                        shift_q <= next_px;
                        bit_cnt <= 5'(PIXEL_BITS - 1);
                        pix_idx <= pix_idx + 17'd1;
                        if (more_after) begin
                            rd_en   <= 1'b1;
                            rd_addr <= ADDR_WIDTH'(pix_idx + 17'd2);
                        end
                    end else begin
                        gap_cnt <= '0;
                    end
                end
                GAP: begin
                    gap_cnt <= gap_cnt + 1'b1;
`ifdef WS2812_TX_REPEAT_EN
                    if (gap_cnt == GW'(RESET_CYC)) begin
                        pix_idx <= '0;
                        rd_en   <= 1'b1;
                        rd_addr <= '0;
                    end
`endif
                end
                default: ;
            endcase
        end
    end

endmodule
